// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: read-latency bounds and counter width.
package mem_responder_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;
    localparam int unsigned CNT_W      = 16;

endpackage

// File: rtl/mem_sp_ram.sv
// Word RAM with one read/write port, one write-only load port and a registered read.
module mem_sp_ram #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_wdata_i
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_d, rdata_q;

    // Main-port write is issued last so it wins over a load to the same word.
    always_ff @(posedge clk_i) begin
        if (ld_we_i) begin
            mem_q[ld_addr_i] <= ld_wdata_i;
        end
        if (req_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (req_i && !we_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: range check, read pipeline, access counters, sticky error.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned MEM_AW = 16,
    parameter int unsigned MEM_DW = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_rdata_vld,
    output logic [MEM_DW-1:0] mem_rdata,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [MEM_DW-1:0] ld_wdata,
    output logic              addr_err,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW:0] DEPTH_W = (MEM_AW + 1)'(DEPTH);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_responder: RD_LAT out of range");
    end

    logic              in_range, ld_in_range, rd_acc, wr_acc;
    logic [MEM_DW-1:0] ram_rdata, stage1;
    logic [RD_LAT-1:0] vld_d, vld_q;
    logic              oor_d, oor_q;
    logic              addr_err_d, addr_err_q;
    logic [CNT_W-1:0]  rd_cnt_d, rd_cnt_q, wr_cnt_d, wr_cnt_q;

    always_comb begin
        in_range    = {1'b0, mem_addr} < DEPTH_W;
        ld_in_range = {1'b0, ld_addr} < DEPTH_W;
        rd_acc      = mem_req & ~mem_write;
        wr_acc      = mem_req & mem_write;
    end

    // Out-of-range writes must not touch the RAM read register either.
    mem_sp_ram #(
        .AW    (IW),
        .DW    (MEM_DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (rd_acc | (wr_acc & in_range)),
        .we_i       (wr_acc & in_range),
        .addr_i     (mem_addr[IW-1:0]),
        .wdata_i    (mem_wdata),
        .rdata_o    (ram_rdata),
        .ld_we_i    (ld_we & ld_in_range),
        .ld_addr_i  (ld_addr[IW-1:0]),
        .ld_wdata_i (ld_wdata)
    );

    always_comb begin
        vld_d[0] = rd_acc;
        for (int k = 1; k < int'(RD_LAT); k++) begin
            vld_d[k] = vld_q[k-1];
        end
        oor_d      = rd_acc ? ~in_range : oor_q;
        addr_err_d = addr_err_q | (mem_req & ~in_range);
        rd_cnt_d   = rd_acc ? rd_cnt_q + 1'b1 : rd_cnt_q;
        wr_cnt_d   = wr_acc ? wr_cnt_q + 1'b1 : wr_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            oor_q      <= 1'b0;
            addr_err_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            vld_q      <= vld_d;
            oor_q      <= oor_d;
            addr_err_q <= addr_err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Stage 1: RAM output, zeroed for out-of-range reads; only changes on a read.
    assign stage1 = oor_q ? '0 : ram_rdata;

    if (RD_LAT == 1) begin : g_lat1
        assign mem_rdata = stage1;
    end else begin : g_latn
        logic [MEM_DW-1:0] dq_d [RD_LAT-1];
        logic [MEM_DW-1:0] dq_q [RD_LAT-1];

        // Each stage loads only when the stage behind it is valid, so the output holds.
        always_comb begin
            dq_d[0] = vld_q[0] ? stage1 : dq_q[0];
            for (int k = 1; k < int'(RD_LAT) - 1; k++) begin
                dq_d[k] = vld_q[k] ? dq_q[k-1] : dq_q[k];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < int'(RD_LAT) - 1; k++) begin
                    dq_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k < int'(RD_LAT) - 1; k++) begin
                    dq_q[k] <= dq_d[k];
                end
            end
        end

        assign mem_rdata = dq_q[RD_LAT-2];
    end

    assign mem_rdata_vld = vld_q[RD_LAT-1];
    assign addr_err      = addr_err_q;
    assign rd_cnt        = rd_cnt_q;
    assign wr_cnt        = wr_cnt_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_AW, default 16, memory address width in words.
REQ-002 Parameter MEM_DW, default 32, data word width.
REQ-003 Parameter DEPTH, default 1024, number of implemented words; legal range 1..2^MEM_AW.
REQ-004 Parameter RD_LAT, default 2, read latency in cycles; legal range 1..4.
REQ-005 The port list SHALL be exactly the following (name, direction, width, meaning):
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  in  1  access request, one access per cycle while high.
- mem_write  in  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  in  MEM_AW  word address.
- mem_wdata  in  MEM_DW  write data.
- mem_rdata_vld  out  1  one-cycle pulse per returned read.
- mem_rdata  out  MEM_DW  read data, valid only when mem_rdata_vld=1.
- ld_we  in  1  side-load write strobe (bench/host preload).
- ld_addr  in  MEM_AW  side-load address.
- ld_wdata  in  MEM_DW  side-load data.
- addr_err  out  1  sticky flag: access to an address >= DEPTH.
- rd_cnt  out  16  number of reads accepted, wraps at 2^16.
- wr_cnt  out  16  number of writes accepted, wraps at 2^16.

Function
REQ-006 Every cycle with mem_req=1 SHALL be accepted; there is no backpressure and no ready signal.
REQ-007 A read accepted in cycle N SHALL raise mem_rdata_vld for exactly one cycle, in cycle N+RD_LAT, with data for mem_addr sampled in cycle N.
REQ-008 Reads SHALL return in issue order; back-to-back reads SHALL produce back-to-back vld pulses with no bubbles.
REQ-009 A write accepted in cycle N SHALL update memory at the end of cycle N; a read of the same address in cycle N+1 SHALL return the new data.
REQ-010 mem_rdata_vld SHALL be 0 for writes and idle cycles; mem_rdata SHALL hold its last value when vld=0.
REQ-011 The read pipeline SHALL be a shift of RD_LAT valid bits plus data stages; stage 1 is the RAM registered output.
REQ-012 An address >= DEPTH SHALL set addr_err (sticky until reset); writes to it SHALL be dropped; reads to it SHALL still pulse vld, with data all-zero.
REQ-013 ld_we=1 SHALL write ld_wdata to ld_addr at end of cycle; if ld_addr >= DEPTH the write is dropped and addr_err is not set.
REQ-014 When ld_we and a mem_req write target the same address in the same cycle, the mem_req write SHALL win.
REQ-015 When ld_we targets the address read by mem_req in the same cycle, the read SHALL return the pre-write (old) contents.
REQ-016 rd_cnt and wr_cnt SHALL increment on each accepted read or write, including out-of-range accesses, and wrap from 0xFFFF to 0.

Reset
REQ-017 rst_n=0 SHALL asynchronously clear mem_rdata_vld, mem_rdata, all pipeline valid and data stages, addr_err, rd_cnt and wr_cnt.
REQ-018 Memory contents SHALL NOT be reset.
REQ-019 Reads in flight when reset asserts SHALL be discarded; no vld pulse SHALL follow reset release for them.
REQ-020 Accesses SHALL be accepted from the first rising edge after rst_n deasserts.

Structure
REQ-021 A shared package SHALL hold the RD_LAT bounds (1, 4) and the counter width constant (16).
REQ-022 The storage SHALL be one sub-module, mem_sp_ram, with one read/write port plus one write-only port, registered read, and no reset on the array.
REQ-023 The latency pipeline, range check, counters and error flag SHALL reside in mem_responder.

Verification
REQ-024 Preload addr 5 with 0x1234 via ld_we, read addr 5 in cycle 10 with RD_LAT=2 -> vld=1 only in cycle 12 with rdata=0x1234.
REQ-025 Write 0xAA at addr 3 in cycle N, read addr 3 in cycle N+1 -> returned data is 0xAA.
REQ-026 Issue 4 consecutive reads at addrs 0..3 (preloaded 10,11,12,13) -> 4 consecutive vld pulses carrying 10,11,12,13; rd_cnt=4.
REQ-027 Read addr DEPTH with DEPTH=1024 -> addr_err=1 and stays 1; vld pulses with rdata=0; a later write to addr 1024 leaves addr 0 unchanged.
REQ-028 Issue a read, assert rst_n=0 one cycle later -> no vld pulse after release; counters and addr_err read 0; memory keeps preloaded values.
REQ-029 In the same cycle, ld_we writes 0x1 and mem_req writes 0x2 to addr 7 -> a later read of addr 7 returns 0x2.
